// File: rtl/bp_fe_gshare_pkg.sv
// Shared types and helpers for the gshare index/history stage.
// Checkpoint record, PC/GHR hash and checkpoint FIFO sizing.
package bp_fe_gshare_pkg;

  localparam int BHT_IDX_W  = 9;
  localparam int GHIST_W    = 9;
  localparam int CKPT_ELS   = 8;
  localparam int CKPT_PTR_W = $clog2(CKPT_ELS);
  localparam int CKPT_CNT_W = CKPT_PTR_W + 1;

  // ghr is held at full index width so any GHR width up to the
  // index width fits; narrower histories are zero-extended.
  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic [BHT_IDX_W-1:0] ghr;
    logic                 pred;
  } bp_gshare_ckpt_s;

  function automatic logic [BHT_IDX_W-1:0] gshare_hash(
    input logic [BHT_IDX_W-1:0] pc_bits,
    input logic [BHT_IDX_W-1:0] ghr
  );
    return pc_bits ^ ghr;
  endfunction

endpackage

// File: rtl/bp_fe_gshare_ckpt_fifo.sv
// Checkpoint FIFO for in-flight branches: push/pop/flush.
// Push while full is honoured when a pop happens in the same cycle.
module bp_fe_gshare_ckpt_fifo
  import bp_fe_gshare_pkg::*;
#(
  parameter int els_p = CKPT_ELS
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  bp_gshare_ckpt_s        data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output bp_gshare_ckpt_s        data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(els_p):0] count_o
);

  localparam int PtrW = $clog2(els_p);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  bp_gshare_ckpt_s mem_q [els_p];

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PtrW+1)'(els_p));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // pointer and occupancy next state; flush empties everything
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      wptr_d = wptr_q + PtrW'(do_push);
      rptr_d = rptr_q + PtrW'(do_pop);
      cnt_d  = cnt_q + (PtrW+1)'(do_push)
                     - (PtrW+1)'(do_pop);
    end
  end

  // pointer and occupancy registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage needs no reset: entries are only read when counted valid
  always_ff @(posedge clk_i) begin
    if (do_push & ~flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bp_fe_gshare_idx_gen.sv
// Gshare index/history stage: hashes PC with GHR, checkpoints branches,
// drives BHT updates and restores GHR on mispredict. Option: BP_GSHARE_IDX_PERF_EN.
module bp_fe_gshare_idx_gen
  import bp_fe_gshare_pkg::*;
#(
  parameter int vaddr_width_p    = 39,
  parameter int bht_idx_width_p  = BHT_IDX_W,
  parameter int ghist_width_p    = GHIST_W,
  parameter int pc_lsb_p         = 2,
  parameter int inflight_els_p   = CKPT_ELS,
  parameter int perf_cnt_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        pc_v_i,
  input  logic [vaddr_width_p-1:0]    pc_i,
  output logic                        ready_o,
  output logic                        r_v_o,
  output logic [bht_idx_width_p-1:0]  idx_r_o,
  input  logic                        predict_i,
  output logic                        pred_v_o,
  output logic                        pred_taken_o,
  input  logic                        res_v_i,
  input  logic                        res_taken_i,
  output logic                        w_v_o,
  output logic [bht_idx_width_p-1:0]  idx_w_o,
  output logic                        correct_o,
  output logic                        mispredict_o,
  output logic [perf_cnt_width_p-1:0] pred_cnt_o,
  output logic [perf_cnt_width_p-1:0] miss_cnt_o
);

  localparam int CntW = $clog2(inflight_els_p) + 1;

  logic                       pending_q, pending_d;
  logic [bht_idx_width_p-1:0] snap_idx_q, snap_idx_d;
  logic [ghist_width_p-1:0]   snap_ghr_q, snap_ghr_d;
  logic [ghist_width_p-1:0]   ghr_q, ghr_d;
  logic [ghist_width_p-1:0]   head_ghr;

  bp_gshare_ckpt_s head, push_data;
  logic            fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_cnt;
  logic            fifo_push, fifo_pop;

  logic accept, full, res_fire, match;
  logic unused_ok;

  assign unused_ok = ^{pc_i, fifo_full};

  assign full    = (fifo_cnt + CntW'(pending_q))
                   == CntW'(inflight_els_p);
  assign ready_o = ~pending_q & ~full;
  assign accept  = pc_v_i & ready_o;
  assign r_v_o   = accept;
  assign idx_r_o = gshare_hash(
                     pc_i[pc_lsb_p +: bht_idx_width_p],
                     BHT_IDX_W'(ghr_q));

  assign res_fire     = res_v_i & ~fifo_empty;
  assign match        = (head.pred == res_taken_i);
  assign w_v_o        = res_fire;
  assign idx_w_o      = res_fire ? head.idx : '0;
  assign correct_o    = res_fire & match;
  assign mispredict_o = res_fire & ~match;
  assign head_ghr     = ghist_width_p'(head.ghr);

  assign pred_v_o     = pending_q & ~mispredict_o;
  assign pred_taken_o = pred_v_o & predict_i;

  assign fifo_push = pred_v_o;
  assign fifo_pop  = correct_o;
  assign push_data = '{idx:  snap_idx_q,
                       ghr:  BHT_IDX_W'(snap_ghr_q),
                       pred: predict_i};

  bp_fe_gshare_ckpt_fifo #(
    .els_p(inflight_els_p)
  ) u_ckpt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (fifo_push),
    .data_i (push_data),
    .pop_i  (fifo_pop),
    .flush_i(mispredict_o),
    .data_o (head),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .count_o(fifo_cnt)
  );

  // history and request tracking; mispredict restore beats everything
  always_comb begin
    pending_d  = pending_q;
    snap_idx_d = snap_idx_q;
    snap_ghr_d = snap_ghr_q;
    ghr_d      = ghr_q;
    if (mispredict_o) begin
      ghr_d     = (head_ghr << 1)
                | ghist_width_p'(res_taken_i);
      pending_d = 1'b0;
    end else begin
      if (pending_q) begin
        ghr_d     = (ghr_q << 1)
                  | ghist_width_p'(predict_i);
        pending_d = 1'b0;
      end
      if (accept) begin
        pending_d  = 1'b1;
        snap_idx_d = idx_r_o;
        snap_ghr_d = ghr_q;
      end
    end
  end

  // history and request registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q  <= 1'b0;
      snap_idx_q <= '0;
      snap_ghr_q <= '0;
      ghr_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      snap_idx_q <= snap_idx_d;
      snap_ghr_q <= snap_ghr_d;
      ghr_q      <= ghr_d;
    end
  end

`ifdef BP_GSHARE_IDX_PERF_EN
  logic [perf_cnt_width_p-1:0] pred_cnt_q, pred_cnt_d;
  logic [perf_cnt_width_p-1:0] miss_cnt_q, miss_cnt_d;

  // free-running event counts, wrapping silently
  always_comb begin
    pred_cnt_d = pred_cnt_q
               + perf_cnt_width_p'(pred_v_o);
    miss_cnt_d = miss_cnt_q
               + perf_cnt_width_p'(mispredict_o);
  end

  // counter registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pred_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      pred_cnt_q <= pred_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign pred_cnt_o = pred_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign pred_cnt_o = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_fe_gshare_idx_gen.sv
// Testbench for bp_fe_gshare_idx_gen: directed table, corner
// sequences and random traffic against a queue-based model.
module tb_bp_fe_gshare_idx_gen;

  localparam int DEPTH = 8;
  localparam int MASK  = 'h1FF;

  logic        clk;
  logic        reset_i;
  logic        pc_v_i;
  logic [38:0] pc_i;
  logic        ready_o, r_v_o;
  logic [8:0]  idx_r_o;
  logic        predict_i;
  logic        pred_v_o, pred_taken_o;
  logic        res_v_i, res_taken_i;
  logic        w_v_o;
  logic [8:0]  idx_w_o;
  logic        correct_o, mispredict_o;
  logic [31:0] pred_cnt_o, miss_cnt_o;

  bp_fe_gshare_idx_gen dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .pc_v_i      (pc_v_i),
    .pc_i        (pc_i),
    .ready_o     (ready_o),
    .r_v_o       (r_v_o),
    .idx_r_o     (idx_r_o),
    .predict_i   (predict_i),
    .pred_v_o    (pred_v_o),
    .pred_taken_o(pred_taken_o),
    .res_v_i     (res_v_i),
    .res_taken_i (res_taken_i),
    .w_v_o       (w_v_o),
    .idx_w_o     (idx_w_o),
    .correct_o   (correct_o),
    .mispredict_o(mispredict_o),
    .pred_cnt_o  (pred_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    int ghr;
    bit pred;
  } ck_t;

  ck_t m_q[$];
  int  m_ghr;
  bit  m_pend;
  int  m_pidx, m_pghr;
  int  m_npred, m_nmiss;

  task automatic model_reset();
    m_q.delete();
    m_ghr = 0;
    m_pend = 0;
    m_pidx = 0;
    m_pghr = 0;
    m_npred = 0;
    m_nmiss = 0;
  endtask

  function automatic int pc_hash(input logic [38:0] pc, input int ghr);
    logic [38:0] sh;
    sh = (pc >> 2) & 39'h1FF;
    return int'(sh) ^ ghr;
  endfunction

  function automatic logic [24:0] mk(
    input bit rdy, input bit rv, input int idx,
    input bit pv, input bit pt, input bit wv,
    input int idxw, input bit corr, input bit mis);
    logic [8:0] i9, w9;
    i9 = idx[8:0];
    w9 = idxw[8:0];
    return {rdy, rv, i9, pv, pt, wv, w9, corr, mis};
  endfunction

  function automatic logic [24:0] model_expect(
    input bit pc_v, input logic [38:0] pc, input bit pred,
    input bit res_v, input bit res_t);
    bit rdy, acc, rslv, corr, mis, pv;
    int idxw;
    rdy  = !m_pend && (m_q.size() < DEPTH);
    acc  = pc_v && rdy;
    rslv = res_v && (m_q.size() != 0);
    corr = rslv && (m_q[0].pred == res_t);
    mis  = rslv && !corr;
    pv   = m_pend && !mis;
    idxw = rslv ? m_q[0].idx : 0;
    return mk(rdy, acc, pc_hash(pc, m_ghr), pv, pv && pred,
              rslv, idxw, corr, mis);
  endfunction

  task automatic model_update(
    input bit pc_v, input logic [38:0] pc, input bit pred,
    input bit res_v, input bit res_t);
    bit rdy, acc, rslv, mis;
    int old_ghr;
    ck_t c;
    old_ghr = m_ghr;
    rdy  = !m_pend && (m_q.size() < DEPTH);
    acc  = pc_v && rdy;
    rslv = res_v && (m_q.size() != 0);
    mis  = rslv && (m_q[0].pred != res_t);
    if (m_pend && !mis) m_npred++;
    if (mis) begin
      m_nmiss++;
      m_ghr = ((m_q[0].ghr * 2) + int'(res_t)) & MASK;
      m_q.delete();
      m_pend = 0;
    end else begin
      if (rslv) void'(m_q.pop_front());
      if (m_pend) begin
        c.idx = m_pidx;
        c.ghr = m_pghr;
        c.pred = pred;
        m_q.push_back(c);
        m_ghr = ((m_ghr * 2) + int'(pred)) & MASK;
        m_pend = 0;
      end
      if (acc) begin
        m_pend = 1;
        m_pidx = pc_hash(pc, old_ghr);
        m_pghr = old_ghr;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] actual();
    return {ready_o, r_v_o, idx_r_o, pred_v_o, pred_taken_o,
            w_v_o, idx_w_o, correct_o, mispredict_o};
  endfunction

  bit s_ready;
  int wv_pulses;

  task automatic step(
    input bit pc_v, input logic [38:0] pc, input bit pred,
    input bit res_v, input bit res_t,
    input bit use_tab, input logic [24:0] tab_exp,
    input string name);
    logic [24:0] e;
    pc_v_i = pc_v;
    pc_i = pc;
    predict_i = pred;
    res_v_i = res_v;
    res_taken_i = res_t;
    #1;
    e = model_expect(pc_v, pc, pred, res_v, res_t);
    check({name, "/model"}, 64'(actual()), 64'(e));
    if (use_tab) check({name, "/table"}, 64'(actual()), 64'(tab_exp));
    s_ready = ready_o;
    if (w_v_o) wv_pulses++;
    @(posedge clk);
    model_update(pc_v, pc, pred, res_v, res_t);
    @(negedge clk);
  endtask

  task automatic go(input bit pc_v, input logic [38:0] pc,
                    input bit pred, input bit res_v,
                    input bit res_t, input string name);
    step(pc_v, pc, pred, res_v, res_t, 1'b0, '0, name);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          pc_v;
    logic [38:0] pc;
    bit          pred;
    bit          res_v;
    bit          res_t;
    logic [24:0] exp;
  } vec_t;

  vec_t tab[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [38:0] rpc;
    reset_i = 1'b1;
    pc_v_i = 0;
    pc_i = '0;
    predict_i = 0;
    res_v_i = 0;
    res_taken_i = 0;
    model_reset();

    tab[0]  = '{0, 39'h0,    0, 0, 0, mk(1,0,'h000,0,0,0,0,0,0)};
    tab[1]  = '{1, 39'h1000, 0, 0, 0, mk(1,1,'h000,0,0,0,0,0,0)};
    tab[2]  = '{1, 39'h1000, 1, 0, 0, mk(0,0,'h000,1,1,0,0,0,0)};
    tab[3]  = '{1, 39'h1010, 0, 0, 0, mk(1,1,'h005,0,0,0,0,0,0)};
    tab[4]  = '{0, 39'h1010, 1, 0, 0, mk(0,0,'h005,1,1,0,0,0,0)};
    tab[5]  = '{1, 39'h1020, 0, 0, 0, mk(1,1,'h00B,0,0,0,0,0,0)};
    tab[6]  = '{0, 39'h1020, 0, 0, 0, mk(0,0,'h00B,1,0,0,0,0,0)};
    tab[7]  = '{1, 39'h1040, 0, 0, 0, mk(1,1,'h016,0,0,0,0,0,0)};
    tab[8]  = '{0, 39'h1040, 1, 1, 1, mk(0,0,'h016,1,1,1,0,1,0)};
    tab[9]  = '{0, 39'h0,    0, 1, 0, mk(1,0,'h00D,0,0,1,5,0,1)};
    tab[10] = '{0, 39'h0,    0, 0, 0, mk(1,0,'h002,0,0,0,0,0,0)};
    tab[11] = '{0, 39'h0,    0, 1, 1, mk(1,0,'h002,0,0,0,0,0,0)};

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 64'(actual()), 64'(mk(1,0,0,0,0,0,0,0,0)));
    check("reset_cnts", {pred_cnt_o, miss_cnt_o}, 64'h0);
    @(negedge clk);
    reset_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tab[i].pc_v, tab[i].pc, tab[i].pred,
           tab[i].res_v, tab[i].res_t, 1'b1, tab[i].exp,
           $sformatf("tab%0d", i));
    end

    // fill to depth, then push and pop together at full occupancy
    while (m_q.size() != 0) go(0, '0, 0, 1, 1, "pre_drain");
    for (int i = 0; i < DEPTH; i++) begin
      rpc = {7'h0, $urandom};
      go(1, rpc, 0, 0, 0, "fill_acc");
      go(0, rpc, 1, 0, 0, "fill_pred");
    end
    go(1, 39'h2000, 0, 0, 0, "full_blocked");
    check("full_ready", 64'(s_ready), 64'h0);
    go(0, '0, 0, 1, 1, "full_pop");
    go(1, 39'h2004, 0, 0, 0, "refill_acc");
    go(0, 39'h2004, 1, 1, 1, "push_pop");
    wv_pulses = 0;
    for (int i = 0; i < DEPTH; i++) go(0, '0, 0, 1, 1, "drain");
    check("drain_pulses", 64'(wv_pulses), 64'd7);

    // mispredict on the push cycle discards the push
    go(1, 39'h3000, 0, 0, 0, "fw_acc0");
    go(0, 39'h3000, 1, 0, 0, "fw_pred0");
    go(1, 39'h3100, 0, 0, 0, "fw_acc1");
    go(0, 39'h3100, 1, 1, 0, "fw_flush");
    go(0, 39'h3100, 0, 1, 1, "fw_empty");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      go($urandom_range(0, 9) < 7, {7'h0, $urandom},
         1'($urandom), $urandom_range(0, 9) < 3,
         1'($urandom), "rand");
    end

`ifdef BP_GSHARE_IDX_PERF_EN
    check("pred_cnt", 64'(pred_cnt_o), 64'(m_npred));
    check("miss_cnt", 64'(miss_cnt_o), 64'(m_nmiss));
`else
    check("pred_cnt_off", 64'(pred_cnt_o), 64'h0);
    check("miss_cnt_off", 64'(miss_cnt_o), 64'h0);
`endif

    // async reset while a request is pending
    go(1, 39'h4000, 0, 0, 0, "mid_acc");
    if (m_pend) begin
      pc_v_i = 0;
      pc_i = '0;
      predict_i = 1;
      res_v_i = 0;
      #2;
      reset_i = 1'b1;
      #1;
      check("rst_mid", 64'(actual()), 64'(mk(1,0,0,0,0,0,0,0,0)));
      @(posedge clk);
      #1;
      check("rst_mid_nopred", 64'(pred_v_o), 64'h0);
      @(negedge clk);
      reset_i = 1'b0;
      model_reset();
    end else begin
      check("mid_pending", 64'(m_pend), 64'h1);
    end
    go(0, '0, 1, 1, 1, "post_rst");
    check("post_rst_cnt", {pred_cnt_o, miss_cnt_o}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
